// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : instr_sequencer
//  Purpose  : Instruction fetch stage that feeds the display FSM. It walks a
//             program counter through a synchronous-read instruction memory,
//             decodes each word and hands CMD/DATA bytes to the FSM over a
//             valid/ready handshake. DELAY words are executed locally, so
//             display power-up/reset timing lives in the program itself.
//             Fetching an END word finishes the program.
//
//  Word format (DATA_WIDTH = 10): [9:8] opcode, [7:0] payload
//    00 CMD   : instr = payload, dc = 0
//    01 DATA  : instr = payload, dc = 1
//    10 DELAY : wait payload * DELAY_TICKS cycles
//    11 END   : pulse done, return to idle
//
//  Ports
//    clk        in   system clock, rising edge
//    reset      in   asynchronous active-high reset
//    start      in   single-cycle run request, honoured only when idle
//    startAddr  in   first instruction address, sampled with start
//    memAddr    out  memory read address (1-cycle read latency)
//    memData    in   memory read data
//    instr      out  byte for the FSM / shift register
//    dc         out  0 = command byte, 1 = data byte
//    instrValid out  instr/dc hold a pending transfer
//    instrReady in   FSM accepts the pending byte
//    busy       out  high whenever not idle
//    done       out  one-cycle pulse at program end
//    overflow   out  sticky; PC ran past the top address without END
//
//  Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 10,
  parameter int DELAY_TICKS = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] startAddr,
  output logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic [7:0]            instr,
  output logic                  dc,
  output logic                  instrValid,
  input  logic                  instrReady,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  // The largest delay is 255 * DELAY_TICKS, which always fits in
  // 8 + clog2(DELAY_TICKS) bits.
  localparam int               CNT_W   = 8 + $clog2(DELAY_TICKS);
  localparam logic [CNT_W-1:0] c_ticks = CNT_W'(DELAY_TICKS);

  localparam logic [1:0] c_op_cmd   = 2'b00;
  localparam logic [1:0] c_op_data  = 2'b01;
  localparam logic [1:0] c_op_delay = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_PRESENT = 3'd3,
    S_DELAY   = 3'd4
  } state_t;

  state_t                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] pc_q,       pc_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic [7:0]            instr_q,    instr_d;
  logic                  dc_q,       dc_d;
  logic                  valid_q,    valid_d;
  logic                  done_q,     done_d;
  logic                  overflow_q, overflow_d;

  logic [1:0]            w_opcode;
  logic [7:0]            w_payload;
  logic                  w_advance;

  assign w_opcode  = memData[DATA_WIDTH-1 -: 2];
  assign w_payload = memData[7:0];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      cnt_q      <= '0;
      instr_q    <= '0;
      dc_q       <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      dc_q       <= dc_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    dc_d       = dc_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    w_advance  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d       = startAddr;
          overflow_d = 1'b0;
          state_d    = S_FETCH;
        end
      end

      // memAddr has been stable for this cycle; the read data shows up in
      // DECODE.
      S_FETCH: begin
        state_d = S_DECODE;
      end

      S_DECODE: begin
        case (w_opcode)
          c_op_cmd, c_op_data: begin
            instr_d = w_payload;
            dc_d    = w_opcode[0];
            valid_d = 1'b1;
            state_d = S_PRESENT;
          end
          c_op_delay: begin
            if (w_payload == 8'd0) begin
              w_advance = 1'b1;
            end else begin
              cnt_d   = CNT_W'(w_payload) * c_ticks;
              state_d = S_DELAY;
            end
          end
          default: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end

      S_PRESENT: begin
        if (instrReady) begin
          valid_d   = 1'b0;
          w_advance = 1'b1;
        end
      end

      // Leaving on the count of 1 makes the time spent here exactly the
      // loaded value.
      S_DELAY: begin
        if (cnt_q == CNT_W'(1)) begin
          w_advance = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Running off the top of memory ends the program instead of wrapping.
    if (w_advance) begin
      if (&pc_q) begin
        overflow_d = 1'b1;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end else begin
        pc_d    = pc_q + ADDR_WIDTH'(1);
        state_d = S_FETCH;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. The read address always tracks the PC, so the PC register
  // drives memAddr directly.
  // --------------------------------------------------------------------------
  assign memAddr    = pc_q;
  assign instr      = instr_q;
  assign dc         = dc_q;
  assign instrValid = valid_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_instr_sequencer
//  Purpose  : Self-checking bench for instr_sequencer. A transaction-level
//             model tracks the program by time (cycles until the next
//             decode/advance) and is compared with the DUT every cycle.
//             Directed programs add literal checks on timing and values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

  localparam int AW    = 8;
  localparam int DW    = 10;
  localparam int TICKS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] startAddr;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memData;
  logic [7:0]    instr;
  logic          dc;
  logic          instrValid;
  logic          instrReady;
  logic          busy;
  logic          done;
  logic          overflow;

  logic [DW-1:0] mem [0:255];

  always #5 clk = ~clk;

  always @(posedge clk) memData <= mem[memAddr];

  instr_sequencer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DELAY_TICKS(TICKS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .startAddr (startAddr),
    .memAddr   (memAddr),
    .memData   (memData),
    .instr     (instr),
    .dc        (dc),
    .instrValid(instrValid),
    .instrReady(instrReady),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: event timing from program semantics.
  // --------------------------------------------------------------------------
  bit         m_run   = 0;
  bit         m_pres  = 0;
  bit         m_isdec = 0;   // pending event is a decode (else a PC advance)
  bit         m_done  = 0;
  bit         m_ovf   = 0;
  bit         m_dc    = 0;
  int         m_wait  = 0;   // clock edges until the pending event
  logic [7:0] m_pc    = '0;
  logic [7:0] m_instr = '0;

  task automatic m_advance();
    if (m_pc == 8'hFF) begin
      m_ovf  = 1;
      m_done = 1;
      m_run  = 0;
    end else begin
      m_pc    = m_pc + 8'd1;
      m_wait  = 2;
      m_isdec = 1;
    end
  endtask

  task automatic m_decode();
    logic [DW-1:0] w;
    w = mem[m_pc];
    case (w[9:8])
      2'b00, 2'b01: begin
        m_pres  = 1;
        m_instr = w[7:0];
        m_dc    = w[8];
      end
      2'b10: begin
        if (w[7:0] == 8'd0) m_advance();
        else begin
          m_wait  = int'(w[7:0]) * TICKS;
          m_isdec = 0;
        end
      end
      default: begin
        m_done = 1;
        m_run  = 0;
      end
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 0; m_pres = 0; m_done = 0; m_ovf = 0;
      m_dc = 0; m_pc = '0; m_instr = '0; m_wait = 0;
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (start) begin
          m_run   = 1;
          m_pc    = startAddr;
          m_ovf   = 0;
          m_wait  = 2;
          m_isdec = 1;
        end
      end else if (m_pres) begin
        if (instrReady) begin
          m_pres = 0;
          m_advance();
        end
      end else begin
        m_wait--;
        if (m_wait == 0) begin
          if (m_isdec) m_decode();
          else         m_advance();
        end
      end
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    check("memAddr",    memAddr,    m_pc);
    check("instrValid", instrValid, m_pres);
    check("busy",       busy,       m_run);
    check("done",       done,       m_done);
    check("overflow",   overflow,   m_ovf);
    check("instr",      instr,      m_instr);
    check("dc",         dc,         m_dc);
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  int         n_busy;
  int         n_done;
  int         vidx[$];
  logic [7:0] vins[$];
  bit         vdc[$];

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 10'h300;
  endtask

  // Starts a program and logs, per cycle (index 0 = first FETCH cycle),
  // every valid byte; returns at the first idle cycle.
  task automatic run_prog(input logic [7:0] a, input int budget);
    n_busy = 0;
    n_done = 0;
    vidx.delete(); vins.delete(); vdc.delete();
    @(negedge clk);
    start = 1; startAddr = a;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < budget; c++) begin
      if (instrValid) begin
        vidx.push_back(c); vins.push_back(instr); vdc.push_back(dc);
      end
      if (done) n_done++;
      if (!busy) break;
      n_busy++;
      @(negedge clk);
    end
    check("run_idle_in_budget", busy, 0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", busy, 0);
  endtask

  function automatic logic [DW-1:0] rand_word();
    int k;
    k = $urandom_range(0, 9);
    if (k < 4)      return {2'b00, 8'($urandom)};
    else if (k < 7) return {2'b01, 8'($urandom)};
    else if (k < 9) return {2'b10, 8'($urandom_range(0, 3))};
    else            return {2'b11, 8'($urandom)};
  endfunction

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    reset = 1; start = 0; startAddr = '0; instrReady = 0;
    clear_mem();
    #1;
    check("reset_instrValid", instrValid, 0);
    check("reset_busy",       busy,       0);
    repeat (2) @(negedge clk);
    check("reset_memAddr",  memAddr,  0);
    check("reset_instr",    instr,    0);
    check("reset_dc",       dc,       0);
    check("reset_done",     done,     0);
    check("reset_overflow", overflow, 0);
    reset = 0;

    // Basic program, ready held high.
    clear_mem();
    mem[0] = 10'h0AE; mem[1] = 10'h155; mem[2] = 10'h300;
    instrReady = 1;
    run_prog(8'h00, 50);
    check("basic_busy_cycles", n_busy, 8);
    check("basic_num_valid",   vidx.size(), 2);
    if (vidx.size() == 2) begin
      check("basic_first_idx",   vidx[0], 2);
      check("basic_second_idx",  vidx[1], 5);
      check("basic_first_byte",  vins[0], 8'hAE);
      check("basic_first_dc",    vdc[0],  0);
      check("basic_second_byte", vins[1], 8'h55);
      check("basic_second_dc",   vdc[1],  1);
    end
    check("basic_done_count", n_done, 1);
    check("basic_overflow",   overflow, 0);

    // Backpressure: hold ready low for 10 valid cycles.
    clear_mem();
    mem[0] = 10'h13C; mem[1] = 10'h300;
    instrReady = 0;
    @(negedge clk);
    start = 1; startAddr = 8'h00;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 10 && !instrValid; c++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_held", instrValid, 1);
      check("bp_instr_held", instr, 8'h3C);
      check("bp_pc_held",    memAddr, 8'h00);
      @(negedge clk);
    end
    check("bp_valid_before_accept", instrValid, 1);
    instrReady = 1;
    @(negedge clk);
    check("bp_valid_after_accept", instrValid, 0);
    check("bp_pc_after_accept",    memAddr, 8'h01);
    wait_idle(50);

    // Delay 3 * 4 = 12 cycles.
    clear_mem();
    mem[0] = 10'h203; mem[1] = 10'h300;
    run_prog(8'h00, 100);
    check("delay_busy_cycles", n_busy, 16);
    check("delay_no_valid",    vidx.size(), 0);
    check("delay_done_count",  n_done, 1);

    // Zero delay.
    clear_mem();
    mem[0] = 10'h200; mem[1] = 10'h300;
    run_prog(8'h00, 50);
    check("zdelay_busy_cycles", n_busy, 4);
    check("zdelay_done_count",  n_done, 1);

    // Overflow off the top address.
    clear_mem();
    mem[8'hFE] = 10'h011; mem[8'hFF] = 10'h122;
    run_prog(8'hFE, 50);
    check("ovf_busy_cycles", n_busy, 6);
    check("ovf_num_valid",   vidx.size(), 2);
    if (vidx.size() == 2) begin
      check("ovf_first_byte",  vins[0], 8'h11);
      check("ovf_second_byte", vins[1], 8'h22);
    end
    check("ovf_done_count", n_done, 1);
    check("ovf_flag",       overflow, 1);
    check("ovf_no_wrap",    memAddr, 8'hFF);

    // Start while busy, then async reset in PRESENT.
    clear_mem();
    mem[8'h10] = 10'h077; mem[8'h11] = 10'h300;
    mem[8'h40] = 10'h199;
    instrReady = 0;
    @(negedge clk);
    start = 1; startAddr = 8'h10;
    @(negedge clk);
    start = 0;
    check("restart_clears_ovf", overflow, 0);
    for (int c = 0; c < 10 && !instrValid; c++) @(negedge clk);
    start = 1; startAddr = 8'h40;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    check("busy_start_pc",    memAddr, 8'h10);
    check("busy_start_instr", instr, 8'h77);
    check("busy_start_valid", instrValid, 1);
    #2 reset = 1;
    #1;
    check("async_rst_valid", instrValid, 0);
    check("async_rst_busy",  busy, 0);
    check("async_rst_pc",    memAddr, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("after_rst_idle", busy, 0);

    // Randomized programs with random backpressure, start pulses and resets.
    for (int r = 0; r < 40; r++) begin
      for (int a = 0; a < 256; a++) mem[a] = rand_word();
      start = 1;
      startAddr = ($urandom_range(0, 2) == 0) ? 8'(8'hF0 + $urandom_range(0, 15)) : 8'($urandom);
      @(negedge clk);
      start = 0;
      for (int c = 0; c < 200; c++) begin
        instrReady = ($urandom_range(0, 3) != 0);
        start      = ($urandom_range(0, 15) == 0);
        startAddr  = 8'($urandom);
        if ($urandom_range(0, 299) == 0) begin
          #2 reset = 1;
          @(negedge clk);
          reset = 0;
        end
        @(negedge clk);
      end
      start = 0;
      instrReady = 1;
      wait_idle(6000);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction fetch stage directly upstream of the display finiteStateMachine.
- Walks a program counter through the instruction memory, decodes each word, and presents the command/data byte plus the D/C flag to the FSM with a valid/ready handshake.
- Executes inline DELAY words locally, so power-up and reset timing for the display lives in memory rather than in the FSM.
- Signals completion when it fetches an END word.

Parameters:
- ADDR_WIDTH, 8, memory address width and program counter width.
- DATA_WIDTH, 10, memory word width. Word format: [9:8] opcode, [7:0] payload.
- DELAY_TICKS, 1000, clk cycles per DELAY payload unit.

Ports:
- clk  in  1  system clock; everything is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to run a program; honoured only in IDLE.
- startAddr  in  ADDR_WIDTH  first instruction address; sampled with start.
- memAddr  out  ADDR_WIDTH  read address to memory (synchronous read, 1-cycle latency).
- memData  in  DATA_WIDTH  read data from memory.
- instr  out  8  byte for the FSM / shift register.
- dc  out  1  0 = command byte, 1 = data byte.
- instrValid  out  1  instr/dc hold a pending transfer.
- instrReady  in  1  FSM accepts the byte (it has loaded the shift register).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at program end.
- overflow  out  1  sticky; set when the PC runs past the top address without reaching END.

Behaviour:
- Reset: asynchronous. Outputs memAddr=0, instr=0, dc=0, instrValid=0, busy=0, done=0, overflow=0; delay counter=0; PC=0; state=IDLE. Reset mid-operation drops instrValid immediately and abandons the program.
- Opcodes:
  - 00 CMD: instr=payload, dc=0.
  - 01 DATA: instr=payload, dc=1.
  - 10 DELAY: wait payload*DELAY_TICKS cycles.
  - 11 END.
- IDLE: on start, PC<=startAddr, memAddr<=startAddr, go to FETCH. overflow clears on start.
- FETCH: one cycle; memAddr=PC is stable. Next state is DECODE.
- DECODE: samples memData.
  - CMD/DATA: register instr/dc, set instrValid, go to PRESENT.
  - DELAY with payload 0: advance the PC immediately and go to FETCH.
  - DELAY with payload >0: load counter = payload*DELAY_TICKS (needs 8+clog2(DELAY_TICKS) bits), go to DELAY.
  - END: pulse done, go to IDLE.
- PRESENT: instrValid stays high and instr/dc hold stable until instrValid && instrReady at a rising edge. On that edge: instrValid<=0, advance the PC, go to FETCH. instrReady outside PRESENT is ignored.
- DELAY: counter decrements each cycle. When it reaches 1, advance the PC and go to FETCH on the same edge. Total cycles spent in DELAY = payload*DELAY_TICKS.
- PC advance:
  - PC<=PC+1, memAddr<=PC+1.
  - If PC is all ones, do not wrap: set overflow, pulse done, go to IDLE.
- Throughput: a CMD/DATA word is presented 2 cycles after FETCH entry; minimum period is 3 cycles per byte when ready is held high.
- start while busy is ignored. start and reset together: reset wins.
- done is high for exactly one cycle; busy falls in the same cycle done is asserted.

Test Plan:
- Basic program. Memory[0..2] = {00_0xAE, 01_0x55, 11_xx}; start with startAddr=0 and instrReady held 1.
  - Required: instr=0xAE with dc=0, then 0x55 with dc=1, each valid exactly 1 cycle, 3 cycles apart.
  - Then done pulses once and busy falls; overflow=0.
- Backpressure. Word 01_0x3C with instrReady=0 for 10 cycles, then 1.
  - Required: instrValid and instr=0x3C held stable all 10 cycles; the PC advances only after the accepting edge.
- Delay. DELAY_TICKS=4, word 10_0x03, then END.
  - Required: exactly 12 cycles in DELAY, no instrValid, then done.
- Zero delay. Word 10_0x00.
  - Required: 0 cycles in DELAY; the next FETCH immediately follows DECODE.
- Overflow. startAddr=0xFE, memory[0xFE..0xFF] = CMD words, no END.
  - Required: both bytes transferred, then overflow=1 and a done pulse; memAddr never wraps to 0.
- Async reset while in PRESENT, and start while busy.
  - Reset mid-PRESENT: instrValid drops without waiting for clk; state returns to IDLE.
  - Second start while busy: no effect on the PC or outputs.
